tour_cmd_seq: RTL

- Reader at the output end of the knight's-tour solver.
- After the solver finishes, walks the stored move list (indices 0..NUM_MOVES-1).
- Decomposes each one-hot knight move into two robot commands: a vertical leg, then a horizontal leg with fanfare.
- Presents the commands to the command processor over the same cmd/cmd_rdy/clr_cmd_rdy handshake the UART path uses. When not touring, it passes UART commands through.

---
 rtl/tour_pkg.sv | 50 +++++
 rtl/tour_move_decode.sv | 62 ++++++
 rtl/tour_cmd_seq.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/tour_pkg.sv
// ---------------------------------------------------------------------------
// tour_pkg
//   Shared definitions for the knight's-tour command sequencer:
//   - robot command opcodes and heading constants
//   - one-hot knight move encodings
//   - sequencer FSM state type
//   - helper to pack a robot command word
//   Optional feature macro used by the top: TOUR_CMD_ABORT_EN.
// ---------------------------------------------------------------------------
package tour_pkg;

    // Robot command word: [15:12] opcode, [11:4] heading, [3:0] squares.
    localparam logic [3:0] OP_ABORT    = 4'h0;
    localparam logic [3:0] OP_MOVE     = 4'h2;
    localparam logic [3:0] OP_MOVE_FAN = 4'h3;

    localparam logic [7:0] HDG_N = 8'h00;
    localparam logic [7:0] HDG_W = 8'h3F;
    localparam logic [7:0] HDG_S = 8'h7F;
    localparam logic [7:0] HDG_E = 8'hBF;

    // One-hot knight moves as stored by the solver, with their (dx,dy).
    localparam logic [7:0] MV_P1_P2 = 8'h01;  // (+1,+2)
    localparam logic [7:0] MV_M1_P2 = 8'h02;  // (-1,+2)
    localparam logic [7:0] MV_M2_P1 = 8'h04;  // (-2,+1)
    localparam logic [7:0] MV_M2_M1 = 8'h08;  // (-2,-1)
    localparam logic [7:0] MV_M1_M2 = 8'h10;  // (-1,-2)
    localparam logic [7:0] MV_P1_M2 = 8'h20;  // (+1,-2)
    localparam logic [7:0] MV_P2_M1 = 8'h40;  // (+2,-1)
    localparam logic [7:0] MV_P2_P1 = 8'h80;  // (+2,+1)

    localparam int         NUM_MOVES_DEF = 24;
    localparam logic [7:0] RESP_ACK_DEF  = 8'hA5;
    localparam logic [7:0] RESP_PROG_DEF = 8'h5A;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_VERT      = 3'd1,
        ST_HOLD_VERT = 3'd2,
        ST_HORZ      = 3'd3,
        ST_HOLD_HORZ = 3'd4
    } tour_cmd_state_t;

    function automatic logic [15:0] mk_cmd(input logic [3:0] op,
                                           input logic [7:0] hdg,
                                           input logic [3:0] sq);
        return {op, hdg, sq};
    endfunction

endpackage

// File: rtl/tour_move_decode.sv
// ---------------------------------------------------------------------------
// tour_move_decode
//   Pure combinational split of a one-hot knight move into two robot legs:
//   the vertical leg (plain move) and the horizontal leg (move with fanfare).
//   A move that is not one-hot yields all-zero commands.
// Ports:
//   move     in  8   one-hot knight move
//   vert_cmd out 16  vertical leg command
//   horz_cmd out 16  horizontal leg command
// ---------------------------------------------------------------------------
module tour_move_decode
    import tour_pkg::*;
(
    input  logic [7:0]  move,
    output logic [15:0] vert_cmd,
    output logic [15:0] horz_cmd
);

    always_comb begin
        vert_cmd = 16'h0000;
        horz_cmd = 16'h0000;
        case (move)
            MV_P1_P2: begin
                vert_cmd = mk_cmd(OP_MOVE,     HDG_N, 4'd2);
                horz_cmd = mk_cmd(OP_MOVE_FAN, HDG_E, 4'd1);
            end
            MV_M1_P2: begin
                vert_cmd = mk_cmd(OP_MOVE,     HDG_N, 4'd2);
                horz_cmd = mk_cmd(OP_MOVE_FAN, HDG_W, 4'd1);
            end
            MV_M2_P1: begin
                vert_cmd = mk_cmd(OP_MOVE,     HDG_N, 4'd1);
                horz_cmd = mk_cmd(OP_MOVE_FAN, HDG_W, 4'd2);
            end
            MV_M2_M1: begin
                vert_cmd = mk_cmd(OP_MOVE,     HDG_S, 4'd1);
                horz_cmd = mk_cmd(OP_MOVE_FAN, HDG_W, 4'd2);
            end
            MV_M1_M2: begin
                vert_cmd = mk_cmd(OP_MOVE,     HDG_S, 4'd2);
                horz_cmd = mk_cmd(OP_MOVE_FAN, HDG_W, 4'd1);
            end
            MV_P1_M2: begin
                vert_cmd = mk_cmd(OP_MOVE,     HDG_S, 4'd2);
                horz_cmd = mk_cmd(OP_MOVE_FAN, HDG_E, 4'd1);
            end
            MV_P2_M1: begin
                vert_cmd = mk_cmd(OP_MOVE,     HDG_S, 4'd1);
                horz_cmd = mk_cmd(OP_MOVE_FAN, HDG_E, 4'd2);
            end
            MV_P2_P1: begin
                vert_cmd = mk_cmd(OP_MOVE,     HDG_N, 4'd1);
                horz_cmd = mk_cmd(OP_MOVE_FAN, HDG_E, 4'd2);
            end
            default: begin
                vert_cmd = 16'h0000;
                horz_cmd = 16'h0000;
            end
        endcase
    end

endmodule

// File: rtl/tour_cmd_seq.sv
// ---------------------------------------------------------------------------
// tour_cmd_seq
//   Replays the solved knight's tour as robot commands. Each stored move
//   becomes a vertical leg followed by a horizontal leg with fanfare. While
//   idle, UART commands pass straight through to the command processor.
//
//   Handshake (both the UART side and the processor side): cmd_rdy is the
//   valid and stays high with cmd stable until the consumer pulses
//   clr_cmd_rdy for one cycle; the consumer later pulses send_resp when the
//   command has been executed, and resp is valid in that cycle.
//
//   Optional macro TOUR_CMD_ABORT_EN: when defined, a UART command with
//   opcode 4'h0 arriving mid-tour aborts back to IDLE (and is consumed).
//   When undefined, UART traffic is ignored until the tour completes.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start_tour          pulse: begin replay (honoured only in IDLE)
//   move[7:0]           one-hot move at mv_indx, from the solver
//   mv_indx[4:0]        index of the move being replayed
//   cmd_UART[15:0]      command from the UART wrapper
//   cmd_rdy_UART        UART command valid
//   clr_cmd_rdy_UART    consume strobe to the UART wrapper
//   cmd[15:0]           command to the command processor
//   cmd_rdy             command valid
//   clr_cmd_rdy         processor has taken cmd
//   send_resp           processor finished the current command
//   resp[7:0]           response byte to the UART
//   state_dbg[2:0]      current FSM state (tour_cmd_state_t encoding)
// ---------------------------------------------------------------------------
module tour_cmd_seq
    import tour_pkg::*;
#(
    parameter int         NUM_MOVES = NUM_MOVES_DEF,
    parameter logic [7:0] RESP_ACK  = RESP_ACK_DEF,
    parameter logic [7:0] RESP_PROG = RESP_PROG_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_tour,
    input  logic [7:0]  move,
    output logic [4:0]  mv_indx,
    input  logic [15:0] cmd_UART,
    input  logic        cmd_rdy_UART,
    output logic        clr_cmd_rdy_UART,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic        send_resp,
    output logic [7:0]  resp,
    output logic [2:0]  state_dbg
);

    localparam logic [4:0] LAST_IDX = 5'(NUM_MOVES - 1);

    tour_cmd_state_t state_q, state_nxt;
    logic [4:0]      mv_indx_q, mv_indx_nxt;
    logic [15:0]     vert_cmd, horz_cmd;
    logic            last_move;
    logic            abort;

    tour_move_decode u_decode (
        .move     (move),
        .vert_cmd (vert_cmd),
        .horz_cmd (horz_cmd)
    );

    assign last_move = (mv_indx_q == LAST_IDX);
    assign mv_indx   = mv_indx_q;
    assign state_dbg = state_q;

`ifdef TOUR_CMD_ABORT_EN
    assign abort = (state_q != ST_IDLE) && cmd_rdy_UART &&
                   (cmd_UART[15:12] == OP_ABORT);
`else
    assign abort = 1'b0;
`endif

    // State register (mv_indx advances together with the state).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            mv_indx_q <= 5'd0;
        end else begin
            state_q   <= state_nxt;
            mv_indx_q <= mv_indx_nxt;
        end
    end

    // Next-state logic. Strobes that do not belong to the current state
    // (start_tour mid-tour, clr_cmd_rdy while holding, send_resp while
    // offering a leg) fall through to "stay".
    always_comb begin
        state_nxt   = state_q;
        mv_indx_nxt = mv_indx_q;
        case (state_q)
            ST_IDLE: begin
                if (start_tour) begin
                    state_nxt   = ST_VERT;
                    mv_indx_nxt = 5'd0;
                end
            end
            ST_VERT: begin
                if (clr_cmd_rdy) state_nxt = ST_HOLD_VERT;
            end
            ST_HOLD_VERT: begin
                if (send_resp) state_nxt = ST_HORZ;
            end
            ST_HORZ: begin
                if (clr_cmd_rdy) state_nxt = ST_HOLD_HORZ;
            end
            ST_HOLD_HORZ: begin
                if (send_resp) begin
                    if (last_move) begin
                        state_nxt = ST_IDLE;
                    end else begin
                        state_nxt   = ST_VERT;
                        mv_indx_nxt = mv_indx_q + 5'd1;
                    end
                end
            end
            default: begin
                state_nxt   = ST_IDLE;
                mv_indx_nxt = 5'd0;
            end
        endcase
        if (abort) begin
            state_nxt   = ST_IDLE;
            mv_indx_nxt = 5'd0;
        end
    end

    // Output logic. During HOLD_* the leg stays on cmd but is not valid.
    always_comb begin
        cmd              = vert_cmd;
        cmd_rdy          = 1'b0;
        clr_cmd_rdy_UART = 1'b0;
        resp             = RESP_PROG;
        case (state_q)
            ST_IDLE: begin
                cmd              = cmd_UART;
                cmd_rdy          = cmd_rdy_UART;
                clr_cmd_rdy_UART = clr_cmd_rdy;
                resp             = RESP_ACK;
            end
            ST_VERT: begin
                cmd_rdy = 1'b1;
            end
            ST_HOLD_VERT: begin
                cmd_rdy = 1'b0;
            end
            ST_HORZ: begin
                cmd     = horz_cmd;
                cmd_rdy = 1'b1;
            end
            ST_HOLD_HORZ: begin
                cmd = horz_cmd;
                if (last_move) resp = RESP_ACK;
            end
            default: begin
                cmd = vert_cmd;
            end
        endcase
        if (abort) clr_cmd_rdy_UART = 1'b1;
    end

endmodule
